// File: rtl/slot_pkg.sv
// Shared types, constants and scorer for the slot-machine reel controller.
// Latency: combinational helpers only.
// Backpressure: none; pure definitions.
package slot_pkg;

  typedef enum logic [2:0] {IDLE, SPIN, STOP, SCORE, SHOW} state_t;

  localparam int DIGIT_W = 4;
  localparam int CNT_W   = 16;

  // Right-shifting Galois mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Active-high {g,f,e,d,c,b,a}; codes 10..15 never occur and are blanked
  localparam logic [6:0] SEG_MAP [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  // Score from the most frequent digit among the first n reels (4 bits each)
  function automatic logic [3:0] score_fn(input logic [31:0] digs, input int n);
    int cnt [10];
    int m;
    int v;
    m = 0;
    for (int i = 0; i < 10; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        v = int'(digs[4*k +: 4]);
        if (v < 10) cnt[v] = cnt[v] + 1;
      end
    end
    for (int i = 0; i < 10; i++) if (cnt[i] > m) m = cnt[i];
    if (m == n) return 4'd10;
    if ((m == n - 1) && (n >= 3)) return 4'd5;
    if (m >= 2) return 4'd1;
    return 4'd0;
  endfunction

endpackage

// File: rtl/slot_reel.sv
// One countdown reel: rolls 9..0 on each tick until it lands on its latched target.
// Latency: digit and stopped update on the clk carrying tick/eligible/resume.
// Backpressure: none; free-running on tick.
module slot_reel
  import slot_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] INIT_DIGIT = 4'd9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               eligible,
  input  logic [DIGIT_W-1:0] target,
  input  logic               resume,
  output logic [DIGIT_W-1:0] digit,
  output logic               stopped
);

  logic               armed;
  logic [DIGIT_W-1:0] target_q;
  logic [DIGIT_W-1:0] next_digit;

  // Digit the reel shows after this tick's advance
  always_comb begin
    next_digit = (digit == '0) ? DIGIT_W'(9) : digit - 1'b1;
  end

  // Roll, then freeze on a match; a target latched this clk is only compared from the next tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit    <= INIT_DIGIT;
      stopped  <= 1'b0;
      armed    <= 1'b0;
      target_q <= '0;
    end else begin
      if (tick && !stopped) digit <= next_digit;
      if (resume) begin
        stopped  <= 1'b0;
        armed    <= 1'b0;
        target_q <= '0;
      end else begin
        if (tick && armed && !stopped && (next_digit == target_q)) stopped <= 1'b1;
        if (eligible) begin
          armed    <= 1'b1;
          target_q <= target;
        end
      end
    end
  end

endmodule

// File: rtl/slot_reel_ctrl.sv
// N-reel slot controller: spin FSM, roll-tick prescaler, LFSR-chosen staggered stops, scorer.
// Latency: busy one clk after the spin edge; done pulses the clk after SCORE.
// Backpressure: none; spin edges outside IDLE are dropped, not queued.
module slot_reel_ctrl
  import slot_pkg::*;
#(
  parameter int          NUM_REELS     = 4,
  parameter int          CLK_HZ        = 700,
  parameter int          ROLL_HZ       = 10,
  parameter int          SPIN_TICKS    = 20,
  parameter int          STAGGER_TICKS = 5,
  parameter int          HOLD_TICKS    = 50,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spin,
  output logic [7*NUM_REELS-1:0] seg,
  output logic [4*NUM_REELS-1:0] digits,
  output logic [NUM_REELS-1:0]   stopped,
  output logic [3:0]             score,
  output logic                   busy,
  output logic                   done
);

  localparam int DIV = CLK_HZ / ROLL_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  state_t               state;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [15:0]          lfsr;
  logic                 spin_q;
  logic                 spin_rise;
  logic [CNT_W-1:0]     tick_cnt;
  logic [DIGIT_W-1:0]   target;
  logic                 resume;
  logic [NUM_REELS-1:0] elig;

  assign tick      = (presc == PW'(DIV - 1));
  assign spin_rise = spin & ~spin_q;
  assign busy      = (state != IDLE);
  assign target    = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
  assign resume    = ((state == IDLE) && spin_rise) ||
                     ((state == SHOW) && tick && (tick_cnt == CNT_W'(HOLD_TICKS - 1)));

  // Roll-tick prescaler, LFSR and spin edge register run in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      lfsr   <= LFSR_SEED;
      spin_q <= 1'b0;
    end else begin
      presc  <= tick ? '0 : presc + 1'b1;
      lfsr   <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
      spin_q <= spin;
    end
  end

  // Spin sequencing; the tick counter restarts at each phase boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      score    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (spin_rise) begin
            state    <= SPIN;
            tick_cnt <= '0;
          end
        end
        SPIN: begin
          if (tick) begin
            if (tick_cnt == CNT_W'(SPIN_TICKS - 1)) begin
              state    <= STOP;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (&stopped) state <= SCORE;
          else if (tick) tick_cnt <= tick_cnt + 1'b1;
        end
        SCORE: begin
          score    <= score_fn(32'(digits), NUM_REELS);
          done     <= 1'b1;
          state    <= SHOW;
          tick_cnt <= '0;
        end
        SHOW: begin
          if (tick) begin
            if (tick_cnt == CNT_W'(HOLD_TICKS - 1)) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
    // Reel k arms on the STOP tick whose pre-increment count is k*STAGGER_TICKS
    assign elig[k] = (state == STOP) && tick && (tick_cnt == CNT_W'(k * STAGGER_TICKS));

    slot_reel #(
      .INIT_DIGIT(DIGIT_W'((9 - k) % 10))
    ) u_reel (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .eligible (elig[k]),
      .target   (target),
      .resume   (resume),
      .digit    (digits[4*k +: 4]),
      .stopped  (stopped[k])
    );

    assign seg[7*k +: 7] = SEG_MAP[digits[4*k +: 4]];
  end

endmodule

// File: tb/tb_slot_reel_ctrl.sv
module tb_slot_reel_ctrl;

  localparam int CLK_HZ  = 8;
  localparam int ROLL_HZ = 2;
  localparam int DIV     = CLK_HZ / ROLL_HZ;
  localparam int SPIN_T  = 3;
  localparam int STAG_T  = 1;
  localparam int HOLD_T  = 4;

  logic clk = 1'b0;
  logic rst;
  logic spin;

  logic [27:0] seg_a;
  logic [15:0] dig_a;
  logic [3:0]  stp_a;
  logic [3:0]  score_a;
  logic        busy_a, done_a;
  logic [13:0] seg_b;
  logic [7:0]  dig_b;
  logic [1:0]  stp_b;
  logic [3:0]  score_b;
  logic        busy_b, done_b;

  always #5 clk = ~clk;

  slot_reel_ctrl #(
    .NUM_REELS(4), .CLK_HZ(CLK_HZ), .ROLL_HZ(ROLL_HZ), .SPIN_TICKS(SPIN_T),
    .STAGGER_TICKS(STAG_T), .HOLD_TICKS(HOLD_T), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst), .spin(spin), .seg(seg_a), .digits(dig_a),
    .stopped(stp_a), .score(score_a), .busy(busy_a), .done(done_a)
  );

  slot_reel_ctrl #(
    .NUM_REELS(2), .CLK_HZ(CLK_HZ), .ROLL_HZ(ROLL_HZ), .SPIN_TICKS(SPIN_T),
    .STAGGER_TICKS(STAG_T), .HOLD_TICKS(HOLD_T), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst), .spin(spin), .seg(seg_b), .digits(dig_b),
    .stopped(stp_b), .score(score_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phases 0 idle, 1 spin, 2 stop, 3 score, 4 show
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int          nr [2] = '{4, 2};
  int          presc;
  logic [15:0] lfsr;
  bit          spin_q;
  int          ph [2];
  int          cnt [2];
  int          scr [2];
  bit          dn [2];
  int          dig [2][8];
  bit          stp [2][8];
  bit          arm [2][8];
  int          tgt [2][8];

  task automatic model_reset();
    presc  = 0;
    lfsr   = 16'hACE1;
    spin_q = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; cnt[d] = 0; scr[d] = 0; dn[d] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        dig[d][k] = (9 - k) % 10; stp[d][k] = 1'b0; arm[d][k] = 1'b0; tgt[d][k] = 0;
      end
    end
  endtask

  function automatic int ref_score(int d);
    int c [10];
    int m;
    m = 0;
    for (int v = 0; v < 10; v++) c[v] = 0;
    for (int k = 0; k < nr[d]; k++) c[dig[d][k]]++;
    for (int v = 0; v < 10; v++) if (c[v] > m) m = c[v];
    if (m == nr[d]) return 10;
    if (m == nr[d] - 1 && nr[d] >= 3) return 5;
    if (m >= 2) return 1;
    return 0;
  endfunction

  task automatic clear_spin(int d);
    for (int k = 0; k < 8; k++) begin
      stp[d][k] = 1'b0; arm[d][k] = 1'b0; tgt[d][k] = 0;
    end
  endtask

  task automatic model_step(input bit spin_in);
    bit tk;
    bit rise;
    int t;
    int nd [8];
    bit allst;
    tk   = (presc == DIV - 1);
    rise = spin_in && !spin_q;
    t    = int'(lfsr[3:0]) % 10;
    for (int d = 0; d < 2; d++) begin
      allst = 1'b1;
      for (int k = 0; k < 8; k++) nd[k] = dig[d][k];
      for (int k = 0; k < nr[d]; k++) begin
        if (tk && !stp[d][k]) nd[k] = (dig[d][k] + 9) % 10;
        if (!stp[d][k]) allst = 1'b0;
      end
      dn[d] = (ph[d] == 3);
      case (ph[d])
        0: if (rise) begin ph[d] = 1; cnt[d] = 0; clear_spin(d); end
        1: if (tk) begin
             cnt[d]++;
             if (cnt[d] == SPIN_T) begin ph[d] = 2; cnt[d] = 0; end
           end
        2: if (allst) ph[d] = 3;
           else if (tk) begin
             for (int k = 0; k < nr[d]; k++) begin
               if (arm[d][k] && !stp[d][k] && nd[k] == tgt[d][k]) stp[d][k] = 1'b1;
               if (cnt[d] == k * STAG_T) begin arm[d][k] = 1'b1; tgt[d][k] = t; end
             end
             cnt[d]++;
           end
        3: begin scr[d] = ref_score(d); ph[d] = 4; cnt[d] = 0; end
        default: if (tk) begin
             cnt[d]++;
             if (cnt[d] == HOLD_T) begin ph[d] = 0; cnt[d] = 0; clear_spin(d); end
           end
      endcase
      for (int k = 0; k < 8; k++) dig[d][k] = nd[k];
    end
    presc  = (presc + 1) % DIV;
    lfsr   = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    spin_q = spin_in;
  endtask

  task automatic cmp_dut(input int d, input logic [63:0] g_dig, input logic [63:0] g_seg,
                         input logic [63:0] g_stp, input logic g_busy, input logic g_done,
                         input logic [3:0] g_score);
    logic [63:0] e_dig, e_seg, e_stp;
    e_dig = '0; e_seg = '0; e_stp = '0;
    for (int k = 0; k < nr[d]; k++) begin
      e_dig[4*k +: 4] = 4'(dig[d][k]);
      e_seg[7*k +: 7] = seg_tab[dig[d][k]];
      e_stp[k]        = stp[d][k];
    end
    chk($sformatf("digits%0d", d), g_dig, e_dig);
    chk($sformatf("seg%0d", d), g_seg, e_seg);
    chk($sformatf("stopped%0d", d), g_stp, e_stp);
    chk($sformatf("busy%0d", d), 64'(g_busy), 64'(ph[d] != 0));
    chk($sformatf("done%0d", d), 64'(g_done), 64'(dn[d]));
    chk($sformatf("score%0d", d), 64'(g_score), 64'(scr[d]));
  endtask

  task automatic cmp_all();
    cmp_dut(0, 64'(dig_a), 64'(seg_a), 64'(stp_a), busy_a, done_a, score_a);
    cmp_dut(1, 64'(dig_b), 64'(seg_b), 64'(stp_b), busy_b, done_b, score_b);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(spin);
    #1;
    cmp_all();
  endtask

  int n_done_a = 0;
  bit mid_rst_hit = 1'b0;

  initial begin
    rst  = 1'b1;
    spin = 1'b0;
    model_reset();

    // Scorer rules on fixed digit patterns
    chk("score_all3",  64'(slot_pkg::score_fn(32'h3333, 4)), 64'd10);
    chk("score_three", 64'(slot_pkg::score_fn(32'h7333, 4)), 64'd5);
    chk("score_pair",  64'(slot_pkg::score_fn(32'h7133, 4)), 64'd1);
    chk("score_none",  64'(slot_pkg::score_fn(32'h3210, 4)), 64'd0);
    chk("score_n2_44", 64'(slot_pkg::score_fn(32'h44, 2)),   64'd10);
    chk("score_n2_45", 64'(slot_pkg::score_fn(32'h45, 2)),   64'd0);

    #12;
    chk("rst_digits", 64'(dig_a), 64'h6789);
    chk("rst_seg0",   64'(seg_a[6:0]), 64'h6F);
    chk("rst_busy",   64'(busy_a), 64'd0);
    chk("rst_score",  64'(score_a), 64'd0);
    cmp_all();
    rst = 1'b0;

    for (int i = 0; i < 4; i++) cycle();
    chk("first_tick_digits", 64'(dig_a), 64'h5678);

    for (int i = 0; i < 8000; i++) begin
      cycle();
      if (done_a) n_done_a++;
      if (!mid_rst_hit && ph[0] == 2 && stp[0][0] && stp[0][1] && !stp[0][2] && !stp[0][3]) begin
        mid_rst_hit = 1'b1;
        #1 rst = 1'b1;
        spin = 1'b0;
        #1;
        chk("midrst_busy",    64'(busy_a), 64'd0);
        chk("midrst_stopped", 64'(stp_a), 64'd0);
        chk("midrst_digits",  64'(dig_a), 64'h6789);
        chk("midrst_score",   64'(score_a), 64'd0);
        model_reset();
        cmp_all();
        #1 rst = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) spin = ~spin;
      end
    end

    chk("mid_reset_reached", 64'(mid_rst_hit), 64'd1);
    chk("spins_completed", 64'(n_done_a > 10), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
